// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU function codes (also used by the ALU), major
// opcodes, the decoded-bundle struct and immediate extraction helpers.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_func_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0] pc;
    alu_func_e   func;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        src1_pc;
    logic        src1_zero;
    logic        src2_imm;
    logic        reg_write;
    logic        illegal;
  } decoded_t;

  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] w);
    return {w[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer: a main (output) register plus one skid
// entry, with a registered in_ready and a flush that empties both entries.
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         in_ready_q, in_ready_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         in_xfer;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    in_xfer      = in_valid_i & in_ready_q;

    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready_i) begin
      // Main is empty or draining: refill from skid first to keep order.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_xfer;
        if (in_xfer) main_data_d = in_data_i;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_data_q  <= main_data_d;
    end
  end

  // NOTE: skid payload is never visible unqualified, so it carries no reset.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decoder feeding the execute-stage ALU through a skid buffer.
// Define DECODE_RVE_EN for RV32E (registers x16-x31 make an instruction illegal).
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      func,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [31:0]     imm,
  output logic            src1_pc,
  output logic            src1_zero,
  output logic            src2_imm,
  output logic            reg_write,
  output logic            illegal
);

`ifdef DECODE_RVE_EN
  localparam bit RVE = 1'b1;
`else
  localparam bit RVE = 1'b0;
`endif

  decoded_t   dec, bundle;
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       use_rs1, use_rs2, writes_rd, bad;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.rs1   = in_inst[19:15];
    dec.rs2   = in_inst[24:20];
    dec.rd    = in_inst[11:7];
    dec.func  = ALU_ADD;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    bad       = 1'b0;

    case (opcode)
      OPC_OP: begin
        {use_rs1, use_rs2, writes_rd} = 3'b111;
        dec.func = alu_func_e'({in_inst[30], f3});
        if (!(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
          bad = 1'b1;
      end
      OPC_OP_IMM: begin
        {use_rs1, writes_rd} = 2'b11;
        dec.src2_imm = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.imm  = {27'b0, in_inst[24:20]};
          dec.func = alu_func_e'({in_inst[30] & f3[2], f3});
          if ((f7 != 7'b0000000 && f7 != 7'b0100000) || (f3 == 3'b001 && in_inst[30]))
            bad = 1'b1;
        end else begin
          dec.imm  = imm_i(in_inst);
          dec.func = alu_func_e'({1'b0, f3});
        end
      end
      OPC_LUI: begin
        writes_rd     = 1'b1;
        dec.src1_zero = 1'b1;
        dec.src2_imm  = 1'b1;
        dec.imm       = imm_u(in_inst);
      end
      OPC_AUIPC: begin
        writes_rd    = 1'b1;
        dec.src1_pc  = 1'b1;
        dec.src2_imm = 1'b1;
        dec.imm      = imm_u(in_inst);
      end
      OPC_LOAD: begin
        {use_rs1, writes_rd} = 2'b11;
        dec.src2_imm = 1'b1;
        dec.imm      = imm_i(in_inst);
      end
      OPC_STORE: begin
        {use_rs1, use_rs2} = 2'b11;
        dec.src2_imm = 1'b1;
        dec.imm      = imm_s(in_inst);
      end
      OPC_BRANCH: begin
        {use_rs1, use_rs2} = 2'b11;
        dec.imm = imm_b(in_inst);
        case (f3[2:1])
          2'b00:   dec.func = ALU_SUB;
          2'b10:   dec.func = ALU_SLT;
          2'b11:   dec.func = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        writes_rd   = 1'b1;
        dec.src1_pc = 1'b1;
        dec.imm     = imm_j(in_inst);
      end
      OPC_JALR: begin
        {use_rs1, writes_rd} = 2'b11;
        dec.src2_imm = 1'b1;
        dec.imm      = imm_i(in_inst);
        if (f3 != 3'b000) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    if (RVE && ((use_rs1 && dec.rs1[4]) || (use_rs2 && dec.rs2[4]) || (writes_rd && dec.rd[4])))
      bad = 1'b1;

    // Illegal bundles still travel to execute, but must not look like an ALU op.
    dec.illegal   = bad;
    dec.reg_write = writes_rd && (dec.rd != 5'd0) && !bad;
    if (bad) dec.func = ALU_ADD;
  end

  skid_buf #(
    .W($bits(decoded_t))
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (dec),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (bundle)
  );

  assign out_pc    = bundle.pc;
  assign func      = bundle.func;
  assign rs1       = bundle.rs1;
  assign rs2       = bundle.rs2;
  assign rd        = bundle.rd;
  assign imm       = bundle.imm;
  assign src1_pc   = bundle.src1_pc;
  assign src1_zero = bundle.src1_zero;
  assign src2_imm  = bundle.src2_imm;
  assign reg_write = bundle.reg_write;
  assign illegal   = bundle.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized traffic
// scored against an arithmetic ISA model and an in-order queue.
module tb_decode_stage;

  localparam logic [3:0] F_ADD = 4'd0, F_SLL = 4'd1, F_SLT = 4'd2, F_SLTU = 4'd3,
                         F_XOR = 4'd4, F_SRL = 4'd5, F_OR = 4'd6, F_AND = 4'd7,
                         F_SUB = 4'd8, F_SRA = 4'd13;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic        in_ready, out_valid, src1_pc, src1_zero, src2_imm, reg_write, illegal;
  logic [31:0] out_pc, imm;
  logic [3:0]  func;
  logic [4:0]  rs1, rs2, rd;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .func(func), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .src1_pc(src1_pc), .src1_zero(src1_zero), .src2_imm(src2_imm),
    .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, imm;
    logic [3:0]  func;
    logic [4:0]  rs1, rs2, rd;
    logic        s1pc, s1z, s2i, rw, ill, u1, u2, ud;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0, n_pass = 0;
  bit          mon_en = 1'b0;
  logic [3:0]  base_f [8] = '{F_ADD, F_SLL, F_SLT, F_SLTU, F_XOR, F_SRL, F_OR, F_AND};
  logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
  endtask

  // ISA reference: immediates are rebuilt with signed arithmetic on the whole word.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int sw, hi, sg;
    logic [2:0] f3;
    logic [6:0] f7;
    sw = w;
    sg = sw >>> 31;
    f3 = w[14:12];
    f7 = w[31:25];
    e = '{default: '0};
    e.pc = pc; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    case (w[6:0])
      7'h33: begin
        e.u1 = 1; e.u2 = 1; e.ud = 1;
        if (f7 == 7'h00) e.func = base_f[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.func = F_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.func = F_SRA;
        else e.ill = 1;
      end
      7'h13: begin
        e.u1 = 1; e.ud = 1; e.s2i = 1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.imm  = 32'(w[24:20]);
          e.func = (f3 == 3'd5 && f7 == 7'h20) ? F_SRA : base_f[f3];
          if (f3 == 3'd1 ? (f7 != 7'h00) : (f7 != 7'h00 && f7 != 7'h20)) e.ill = 1;
        end else begin
          hi = sw >>> 20; e.imm = hi; e.func = base_f[f3];
        end
      end
      7'h37: begin e.ud = 1; e.s1z = 1; e.s2i = 1; e.imm = w & 32'hFFFFF000; end
      7'h17: begin e.ud = 1; e.s1pc = 1; e.s2i = 1; e.imm = w & 32'hFFFFF000; end
      7'h03: begin e.u1 = 1; e.ud = 1; e.s2i = 1; hi = sw >>> 20; e.imm = hi; end
      7'h23: begin
        e.u1 = 1; e.u2 = 1; e.s2i = 1;
        hi = sw >>> 25; e.imm = hi * 32 + 32'(w[11:7]);
      end
      7'h63: begin
        e.u1 = 1; e.u2 = 1;
        e.imm = sg * 4096 + 32'(w[7]) * 2048 + 32'(w[30:25]) * 32 + 32'(w[11:8]) * 2;
        if (f3 == 3'd0 || f3 == 3'd1) e.func = F_SUB;
        else if (f3 == 3'd4 || f3 == 3'd5) e.func = F_SLT;
        else if (f3 == 3'd6 || f3 == 3'd7) e.func = F_SLTU;
        else e.ill = 1;
      end
      7'h6F: begin
        e.ud = 1; e.s1pc = 1;
        e.imm = sg * (1 << 20) + 32'(w[19:12]) * 4096 + 32'(w[20]) * 2048 + 32'(w[30:21]) * 2;
      end
      7'h67: begin
        e.u1 = 1; e.ud = 1; e.s2i = 1; hi = sw >>> 20; e.imm = hi;
        if (f3 != 3'd0) e.ill = 1;
      end
      default: e.ill = 1;
    endcase
`ifdef DECODE_RVE_EN
    if ((e.u1 && w[19]) || (e.u2 && w[24]) || (e.ud && w[11])) e.ill = 1;
`endif
    if (e.ill) e.func = F_ADD;
    e.rw = e.ud && (e.rd != 5'd0) && !e.ill;
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = opcs[k];
    if ((k == 0 || k == 1) && $urandom_range(0, 4) != 0)
      w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  // Scoreboard: outputs are compared against the queue head on every valid cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid_vs_model", 32'(out_valid), 32'(q.size() > 0));
      check("in_ready_vs_model", 32'(in_ready), 32'(q.size() < 2));
      if (out_valid && q.size() > 0) begin
        check("pc", out_pc, q[0].pc);
        check("illegal", 32'(illegal), 32'(q[0].ill));
        check("reg_write", 32'(reg_write), 32'(q[0].rw));
        check("func", 32'(func), 32'(q[0].func));
        if (!q[0].ill) begin
          check("imm", imm, q[0].imm);
          check("src1_pc", 32'(src1_pc), 32'(q[0].s1pc));
          check("src1_zero", 32'(src1_zero), 32'(q[0].s1z));
          check("src2_imm", 32'(src2_imm), 32'(q[0].s2i));
          if (q[0].ud) check("rd", 32'(rd), 32'(q[0].rd));
          if (q[0].u1) check("rs1", 32'(rs1), 32'(q[0].rs1));
          if (q[0].u2) check("rs2", 32'(rs2), 32'(q[0].rs2));
        end
      end
      if (rst || flush) q.delete();
      else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && in_ready) q.push_back(model(in_inst, in_pc));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_inst = w; in_pc = pc;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin ok = 1'b1; cyc(); break; end
      cyc();
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_func"}, 32'(func), 32'd0);
    check({tag, "_imm"}, imm, 32'd0);
    check({tag, "_selects"}, 32'({src1_pc, src1_zero, src2_imm, reg_write}), 32'd0);
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  initial begin
    cyc();
    mon_en = 1'b1;
    cyc();
    check_reset_state("reset");
    rst = 1'b0;
    cyc();

    // addi x1,x0,5 appears exactly one cycle after transfer
    send(32'h00500093, 32'h100);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_func", 32'(func), 32'(F_ADD));
    check("addi_rd", 32'(rd), 32'd1);
    check("addi_rs1", 32'(rs1), 32'd0);
    check("addi_imm", imm, 32'd5);
    check("addi_src2_imm", 32'(src2_imm), 32'd1);
    check("addi_reg_write", 32'(reg_write), 32'd1);
    cyc();
    send(32'h402081B3, 32'h104);
    check("sub_func", 32'(func), 32'(F_SUB));
    check("sub_regs", 32'({rs1, rs2, rd}), 32'({5'd1, 5'd2, 5'd3}));
    check("sub_src2_imm", 32'(src2_imm), 32'd0);
    send(32'h40335293, 32'h108);
    check("srai_func", 32'(func), 32'(F_SRA));
    check("srai_imm", imm, 32'd3);
    send(32'h123453B7, 32'h10C);
    check("lui_imm", imm, 32'h12345000);
    check("lui_src1_zero", 32'(src1_zero), 32'd1);
    check("lui_func", 32'(func), 32'(F_ADD));
    send(32'h00000000, 32'h110);
    check("zero_illegal", 32'(illegal), 32'd1);
    check("zero_reg_write", 32'(reg_write), 32'd0);
    send(32'h01000893, 32'h114);
`ifdef DECODE_RVE_EN
    check("rve_x17_illegal", 32'(illegal), 32'd1);
`else
    check("rv32i_x17_illegal", 32'(illegal), 32'd0);
    check("rv32i_x17_rd", 32'(rd), 32'd17);
`endif
    cyc();

    // Backpressure: skid fills, in_ready drops, all three emerge in order
    out_ready = 1'b0;
    send(32'h00100113, 32'h200);
    check("bp_ready_after_1", 32'(in_ready), 32'd1);
    send(32'h00200193, 32'h204);
    check("bp_ready_after_2", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_inst = 32'h00300213; in_pc = 32'h208;
    cyc();
    check("bp_held_pc", out_pc, 32'h200);
    out_ready = 1'b1;
    send(32'h00300213, 32'h208);
    repeat (4) cyc();
    check("bp_drained", 32'(q.size()), 32'd0);

    // Flush with both entries full and a simultaneous offer
    out_ready = 1'b0;
    send(32'h00400293, 32'h300);
    send(32'h00500313, 32'h304);
    in_valid = 1'b1; in_inst = 32'h00600393; in_pc = 32'h308; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) cyc();

    // Flush beats an offer that in_ready would have accepted and an output transfer
    out_ready = 1'b0;
    send(32'h00700413, 32'h400);
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00800493; in_pc = 32'h404; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_out_valid", 32'(out_valid), 32'd0);
    repeat (2) cyc();

    // Reset mid-stall
    out_ready = 1'b0;
    send(32'h00900513, 32'h500);
    send(32'h00A00593, 32'h504);
    rst = 1'b1;
    cyc();
    check_reset_state("midstall_reset");
    rst = 1'b0; out_ready = 1'b1;
    cyc();

    // Full rate: one bundle per cycle with out_ready high
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_inst = gen_inst(); in_pc = 32'h1000 + 32'(i * 4);
      cyc();
      check("fullrate_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;

    // Randomized traffic with backpressure, flushes and occasional reset
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_inst   = gen_inst();
      in_pc     = $urandom & 32'hFFFFFFFC;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 255) == 0);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (5) cyc();
    check("final_drained", 32'(q.size()), 32'd0);
    check("final_out_valid", 32'(out_valid), 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
